rom_burst_reader: RTL
=====================

Name: rom_burst_reader

Overview:
- Read-side sequencer for the synchronous-read single-port block RAM/ROM macros in this library, e.g. the 64x20 initialized microcode RAM.
- On a start command it walks a window of addresses from a base address and absorbs the RAM's fixed 1-cycle read latency.
- It presents the words as a valid/ready stream with full backpressure, at one word per cycle when the sink is always ready.
- It sits between the RAM read port (addr/dout) and a downstream consumer such as a decoder or loader.

Parameters:
- AW, 6, RAM address width; depth = 2**AW.
- DW, 20, RAM data width.

Ports:
- clk  input  1  sole clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle command strobe; sampled only when busy=0.
- base_addr  input  AW  first address of the burst; sampled with start.
- length  input  AW+1  number of words, 0..2**AW; sampled with start.
- busy  output  1  high from the cycle after start is accepted until the cycle done is asserted.
- done  output  1  one-cycle pulse at the end of the burst.
- mem_re  output  1  read strobe to the RAM.
- mem_addr  output  AW  registered read address to the RAM.
- mem_rdata  input  DW  RAM dout; valid in the cycle after the mem_re/mem_addr cycle.
- out_valid  output  1  stream word available.
- out_ready  input  1  sink accepts the word.
- out_data  output  DW  stream word.
- out_last  output  1  marks the final word of the burst; qualified by out_valid.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - busy, done, mem_re, out_valid, out_last = 0.
  - mem_addr, out_data = 0.
  - FIFO empty; state IDLE.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - start=1 with length>0 → RUN. Load rd_ptr=base_addr, issue_cnt=length, pop_cnt=length.
  - start=1 with length=0 → stay in IDLE and pulse done in the next cycle. No read is issued and out_valid never asserts.
- RUN:
  - Issue rule: mem_re=1 in a cycle when issue_cnt>0 and (fifo_count + inflight − pop_now) < 2, where pop_now = out_valid & out_ready in that cycle.
  - Each issue post-increments rd_ptr modulo 2**AW (63 wraps to 0) and decrements issue_cnt.
  - Reaching issue_cnt=0 → FLUSH.
- FLUSH:
  - Wait until pop_cnt reaches 0, i.e. the last word is handshaken.
  - Then pulse done=1 in the following cycle, drop busy in that same cycle, and return to IDLE.
- Read capture:
  - inflight is a 1-bit flag set on each issue.
  - Each mem_rdata is written into a 2-entry FIFO in the cycle after its issue.
  - The issue rule guarantees the FIFO never overflows, so no captured word is ever dropped.
- Output stage:
  - out_valid, out_data and out_last are driven from the FIFO head register; there is no combinational path from mem_rdata to out_data.
  - out_last = 1 when out_valid and pop_cnt = 1.
  - A handshake (out_valid & out_ready) pops the FIFO and decrements pop_cnt.
  - While out_valid=1 and out_ready=0, out_data and out_last are held stable.
- Latency and throughput:
  - start accepted at edge T → first mem_re at cycle T+1 → first out_valid at T+3.
  - With out_ready held high, one word is output per cycle, so an N-word burst completes its last handshake at T+N+2.
- A start asserted while busy=1 is ignored, including base_addr and length.
- Reset mid-burst: the burst is abandoned immediately, with no done pulse and no further mem_re.
- Width rules:
  - length is AW+1 bits so that the full depth 2**AW is legal.
  - Any length value above 2**AW is clamped to 2**AW.

Decomposition:
- Shared package rom_rd_pkg holds:
  - the state enum typedef (IDLE, RUN, FLUSH);
  - the localparam for FIFO depth (2);
  - the helper function next_addr(addr), which increments modulo 2**AW.
- One sub-module, rom_rd_skid_fifo: a 2-entry register FIFO with push, pop, count, head data and last flag.
- The issue/credit logic and the FSM stay in the top level.

Test Plan:
1. Basic burst: with RAM preloaded with the standard 64x20 image, base=0, length=4, out_ready=1.
   → out_data 0x0400D, 0x08201, 0x02341, 0x0030D on consecutive cycles; first word at T+3; out_last only on 0x0030D; done one cycle after the last handshake.
2. Wrap: base=62, length=4.
   → mem_addr sequence 62, 63, 0, 1; out_data 0x00300, 0x0200A, 0x0400D, 0x08201.
3. Backpressure: base=8, length=6, out_ready random 50% duty.
   → exactly 0x00304, 0x04004, 0x02237, 0x00102, 0x00301, 0x02036 in order, with no duplicates or drops, and out_data stable during every stall.
   → Checker asserts at most 2 words buffered and never a push into a full FIFO.
4. Zero length and ignored start: length=0 → done pulses once, with no mem_re and no out_valid.
   → Then a second start asserted during a 10-word burst is ignored: exactly 10 words are output and there is one done.
5. Full sweep: base=5, length=64, out_ready=1.
   → 64 words covering all addresses, ending at address 4; last handshake at T+66.
6. Reset mid-burst: assert rst_n=0 after the 3rd handshake of a 16-word burst.
   → All outputs go to 0 asynchronously, with no done pulse.
   → A new burst after reset (base=0, length=1) returns 0x0400D with out_last=1.

Source files
------------

// File: rtl/rom_rd_pkg.sv
// -----------------------------------------------------------------------------
// rom_rd_pkg
// Shared definitions for the ROM/RAM burst reader:
//   rd_state_e  : sequencer states (IDLE, RUN, FLUSH)
//   FIFO_DEPTH  : capacity of the output skid FIFO (words)
//   FIFO_CW     : width of the FIFO occupancy count
//   next_addr() : read-pointer increment; the caller truncates the result to
//                 its own address width, which makes the increment wrap
//                 modulo 2**AW.
// -----------------------------------------------------------------------------
package rom_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } rd_state_e;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);

    function automatic logic [31:0] next_addr(input logic [31:0] addr);
        return addr + 32'd1;
    endfunction

endpackage

// File: rtl/rom_rd_skid_fifo.sv
// -----------------------------------------------------------------------------
// rom_rd_skid_fifo
// Two-entry register FIFO. Entry 0 is always the head, so the head word and
// its last flag come straight from registers.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data/push_last (ignored when full without pop)
//   pop         : drop the head word (ignored when empty)
//   count       : current occupancy (0..FIFO_DEPTH)
//   head_data   : head word
//   head_last   : head last flag; cleared whenever the FIFO becomes empty
// -----------------------------------------------------------------------------
module rom_rd_skid_fifo
    import rom_rd_pkg::*;
#(
    parameter int DW = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [DW-1:0]      push_data,
    input  logic               push_last,
    input  logic               pop,
    output logic [FIFO_CW-1:0] count,
    output logic [DW-1:0]      head_data,
    output logic               head_last
);

    localparam logic [FIFO_CW-1:0] CNT_EMPTY = {FIFO_CW{1'b0}};
    localparam logic [FIFO_CW-1:0] CNT_ONE   = {{(FIFO_CW-1){1'b0}}, 1'b1};
    localparam logic [FIFO_CW-1:0] CNT_FULL  = FIFO_CW'(FIFO_DEPTH);

    logic [DW-1:0]      data0_r;
    logic [DW-1:0]      data1_r;
    logic               last0_r;
    logic               last1_r;
    logic [FIFO_CW-1:0] count_r;
    logic               pop_ok_s;
    logic               push_ok_s;

    // Qualify push/pop against the current occupancy.
    always_comb begin
        pop_ok_s  = pop && (count_r != CNT_EMPTY);
        push_ok_s = push && ((count_r != CNT_FULL) || pop_ok_s);
    end

    // Storage and occupancy update; entry 1 shifts into entry 0 on a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data0_r <= {DW{1'b0}};
            data1_r <= {DW{1'b0}};
            last0_r <= 1'b0;
            last1_r <= 1'b0;
            count_r <= CNT_EMPTY;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    if (count_r == CNT_EMPTY) begin
                        data0_r <= push_data;
                        last0_r <= push_last;
                    end else begin
                        data1_r <= push_data;
                        last1_r <= push_last;
                    end
                    count_r <= count_r + CNT_ONE;
                end
                2'b01: begin
                    if (count_r == CNT_FULL) begin
                        data0_r <= data1_r;
                        last0_r <= last1_r;
                    end else begin
                        // Becoming empty: keep data, clear the last flag.
                        last0_r <= 1'b0;
                    end
                    count_r <= count_r - CNT_ONE;
                end
                2'b11: begin
                    if (count_r == CNT_ONE) begin
                        data0_r <= push_data;
                        last0_r <= push_last;
                    end else begin
                        data0_r <= data1_r;
                        last0_r <= last1_r;
                        data1_r <= push_data;
                        last1_r <= push_last;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign count     = count_r;
    assign head_data = data0_r;
    assign head_last = last0_r;

endmodule

// File: rtl/rom_burst_reader.sv
// -----------------------------------------------------------------------------
// rom_burst_reader
// Read sequencer for synchronous-read (1-cycle latency) block RAM/ROM. A start
// command walks `length` words from `base_addr` (wrapping at 2**AW) and
// delivers them as a valid/ready stream with full backpressure.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start/base_addr/length: burst command, sampled only while busy=0
//   busy, done            : burst in progress / one-cycle completion pulse
//   mem_re, mem_addr      : RAM read strobe and (registered) read address
//   mem_rdata             : RAM data, valid the cycle after mem_re
//   out_valid/out_ready   : stream handshake
//   out_data, out_last    : stream word and end-of-burst marker
// -----------------------------------------------------------------------------
module rom_burst_reader #(
    parameter int AW = 6,
    parameter int DW = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   length,
    output logic          busy,
    output logic          done,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    import rom_rd_pkg::*;

    localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] CNT_FULL = {1'b1, {AW{1'b0}}};

    rd_state_e          state_r;
    rd_state_e          state_s;
    logic [AW-1:0]      rd_ptr_r;
    logic [AW:0]        issue_cnt_r;
    logic [AW:0]        pop_cnt_r;
    logic [AW:0]        len_clamped_s;
    logic               inflight_r;
    logic               inflight_last_r;
    logic               busy_r;
    logic               done_r;
    logic               done_s;
    logic               load_s;
    logic               pop_s;
    logic               issue_s;
    logic               last_pop_s;
    logic [2:0]         credit_s;
    logic [FIFO_CW-1:0] fifo_count_s;

    // Clamp the requested length to the RAM depth.
    always_comb begin
        if (length > CNT_FULL) begin
            len_clamped_s = CNT_FULL;
        end else begin
            len_clamped_s = length;
        end
    end

    // Issue credit: a new read may go out only if, after this cycle's pop,
    // the buffered words plus the read in flight leave room for it.
    always_comb begin
        pop_s      = out_valid && out_ready;
        credit_s   = {{(3-FIFO_CW){1'b0}}, fifo_count_s} + {2'b00, inflight_r}
                     - {2'b00, pop_s};
        issue_s    = (state_r == ST_RUN) && (issue_cnt_r != CNT_ZERO)
                     && (credit_s < 3'(FIFO_DEPTH));
        last_pop_s = pop_s && (pop_cnt_r == CNT_ONE);
    end

    // Next-state and command decode.
    always_comb begin
        state_s = state_r;
        done_s  = 1'b0;
        load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len_clamped_s != CNT_ZERO) begin
                        state_s = ST_RUN;
                        load_s  = 1'b1;
                    end else begin
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if ((issue_s && (issue_cnt_r == CNT_ONE)) || (issue_cnt_r == CNT_ZERO)) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // Leave on the last handshake so done follows it directly.
                if (last_pop_s || (pop_cnt_r == CNT_ZERO)) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, busy and done registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= done_s;
        end
    end

    // Read pointer, issue/pop counters and the in-flight read tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r        <= {AW{1'b0}};
            issue_cnt_r     <= CNT_ZERO;
            pop_cnt_r       <= CNT_ZERO;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            inflight_r      <= issue_s;
            inflight_last_r <= issue_s && (issue_cnt_r == CNT_ONE);
            if (load_s) begin
                rd_ptr_r    <= base_addr;
                issue_cnt_r <= len_clamped_s;
                pop_cnt_r   <= len_clamped_s;
            end else begin
                if (issue_s) begin
                    rd_ptr_r    <= AW'(next_addr(32'(rd_ptr_r)));
                    issue_cnt_r <= issue_cnt_r - CNT_ONE;
                end
                if (pop_s && (pop_cnt_r != CNT_ZERO)) begin
                    pop_cnt_r <= pop_cnt_r - CNT_ONE;
                end
            end
        end
    end

    // RAM data lands in the FIFO the cycle after its read; the last word of
    // the burst carries its last flag through the FIFO.
    rom_rd_skid_fifo #(
        .DW (DW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_r),
        .push_data (mem_rdata),
        .push_last (inflight_last_r),
        .pop       (pop_s),
        .count     (fifo_count_s),
        .head_data (out_data),
        .head_last (out_last)
    );

    assign out_valid = (fifo_count_s != {FIFO_CW{1'b0}});
    assign mem_re    = issue_s;
    assign mem_addr  = rd_ptr_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule
